// File: rtl/encoder_qdec_if.sv
// Contact inputs and step/phase outputs of the quadrature decoder.
// The slave side is the decoder; the master side drives the encoder contacts.
interface encoder_qdec_if;
    logic       i_a;
    logic       i_b;
    logic       i_en;
    logic       o_plus;
    logic       o_minus;
    logic       o_err;
    logic [1:0] o_phase;

    modport master (output i_a, i_b, i_en, input o_plus, o_minus, o_err, o_phase);
    modport slave  (input i_a, i_b, i_en, output o_plus, o_minus, o_err, o_phase);
endinterface

// File: rtl/encoder_qdec.sv
// Quadrature encoder decoder: 2-flop sync, optional debounce, Gray decode, detent accumulator.
// Define ENCODER_QDEC_DEBOUNCE_EN to add the per-contact stability counters.
module encoder_qdec #(
    parameter int unsigned STEPS_PER_DETENT = 4,
    parameter int unsigned DEBOUNCE_CYCLES  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    encoder_qdec_if.slave bus
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic signed [3:0] STEP_P = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] STEP_N = -STEP_P;

    if (!(STEPS_PER_DETENT == 1 || STEPS_PER_DETENT == 2 || STEPS_PER_DETENT == 4)) begin : g_bad_steps
        $error("STEPS_PER_DETENT must be 1, 2 or 4");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..65535");
    end

    logic       a_m_q, b_m_q, a_s_q, b_s_q;
    logic [1:0] vcnt_q;
    logic       a_f, b_f, f_valid;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            a_m_q  <= 1'b0;
            b_m_q  <= 1'b0;
            a_s_q  <= 1'b0;
            b_s_q  <= 1'b0;
            vcnt_q <= '0;
        end else begin
            a_m_q <= bus.i_a;
            b_m_q <= bus.i_b;
            a_s_q <= a_m_q;
            b_s_q <= b_m_q;
            if (vcnt_q != 2'd2) vcnt_q <= vcnt_q + 2'd1;
        end
    end

`ifdef ENCODER_QDEC_DEBOUNCE_EN
    logic [15:0] a_cnt_q, b_cnt_q;
    logic        a_f_q, b_f_q, seeded_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            a_cnt_q  <= '0;
            b_cnt_q  <= '0;
            a_f_q    <= 1'b0;
            b_f_q    <= 1'b0;
            seeded_q <= 1'b0;
        end else if (!seeded_q) begin
            // Seed from the first synchronised sample so no spurious change is seen.
            if (vcnt_q == 2'd2) begin
                a_f_q    <= a_s_q;
                b_f_q    <= b_s_q;
                seeded_q <= 1'b1;
            end
        end else begin
            if (a_s_q == a_f_q) begin
                a_cnt_q <= '0;
            end else if (a_cnt_q == 16'(DEBOUNCE_CYCLES - 1)) begin
                a_f_q   <= a_s_q;
                a_cnt_q <= '0;
            end else begin
                a_cnt_q <= a_cnt_q + 16'd1;
            end
            if (b_s_q == b_f_q) begin
                b_cnt_q <= '0;
            end else if (b_cnt_q == 16'(DEBOUNCE_CYCLES - 1)) begin
                b_f_q   <= b_s_q;
                b_cnt_q <= '0;
            end else begin
                b_cnt_q <= b_cnt_q + 16'd1;
            end
        end
    end

    assign a_f     = a_f_q;
    assign b_f     = b_f_q;
    assign f_valid = seeded_q;
`else
    assign a_f     = a_s_q;
    assign b_f     = b_s_q;
    assign f_valid = (vcnt_q == 2'd2);
`endif

    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        case (g)
            2'b00:   gray_pos = 2'd0;
            2'b01:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d, new_ph, pos_dif;
    logic signed [3:0]  acc_q, acc_d, delta, sum;
    logic               plus_q, plus_d, minus_q, minus_d, err_q, err_d;

    always_comb begin
        new_ph  = {a_f, b_f};
        // Position difference mod 4: 1 = clockwise, 3 = reverse, 2 = skipped phase.
        pos_dif = gray_pos(new_ph) - gray_pos(phase_q);
        delta   = (pos_dif == 2'd1) ? 4'sd1 : ((pos_dif == 2'd3) ? -4'sd1 : 4'sd0);
        sum     = acc_q + delta;
        state_d = state_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        plus_d  = 1'b0;
        minus_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (f_valid) begin
                    phase_d = new_ph;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                phase_d = new_ph;
                if (pos_dif == 2'd2) begin
                    err_d = 1'b1;
                    acc_d = '0;
                end else if (!bus.i_en) begin
                    acc_d = '0;
                end else if (sum == STEP_P) begin
                    plus_d = 1'b1;
                    acc_d  = '0;
                end else if (sum == STEP_N) begin
                    minus_d = 1'b1;
                    acc_d   = '0;
                end else begin
                    acc_d = sum;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_INIT;
            phase_q <= '0;
            acc_q   <= '0;
            plus_q  <= 1'b0;
            minus_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            plus_q  <= plus_d;
            minus_q <= minus_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_plus  = plus_q;
    assign bus.o_minus = minus_q;
    assign bus.o_err   = err_q;
    assign bus.o_phase = phase_q;
endmodule

// File: tb/tb_encoder_qdec.sv
// Bench for encoder_qdec: two instances (4 and 1 steps per detent) share one contact stimulus;
// a detent table, reset sequences and random rotation are checked against a history-based model.
module tb_encoder_qdec;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    encoder_qdec_if bus4 ();
    encoder_qdec_if bus1 ();

    encoder_qdec #(.STEPS_PER_DETENT(4), .DEBOUNCE_CYCLES(16)) u_dut4 (
        .i_clk(clk), .i_rst(rst_n), .bus(bus4));
    encoder_qdec #(.STEPS_PER_DETENT(1), .DEBOUNCE_CYCLES(16)) u_dut1 (
        .i_clk(clk), .i_rst(rst_n), .bus(bus1));

    typedef struct packed {
        logic [11:0] seq;
        logic [2:0]  len;
        logic        en;
        logic [3:0]  p4, m4, e, p1, m1;
    } row_t;

    localparam int HOLD = 20;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] ab_h [$];
    logic       en_h [$];
    int         acc_m   [2];
    int         steps_m [2] = '{4, 1};
    int         cnt_p [2], cnt_m [2], cnt_e [2];

    function automatic logic [1:0] cw_next(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ccw_next(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] ab, input logic en);
        bus4.i_a = ab[1]; bus4.i_b = ab[0]; bus4.i_en = en;
        bus1.i_a = ab[1]; bus1.i_b = ab[0]; bus1.i_en = en;
        ab_h.push_back(ab);
        en_h.push_back(en);
    endtask

    task automatic sample(output logic [1:0] ph [2], output logic pl [2], output logic mi [2],
                          output logic er [2]);
        ph[0] = bus4.o_phase; pl[0] = bus4.o_plus; mi[0] = bus4.o_minus; er[0] = bus4.o_err;
        ph[1] = bus1.o_phase; pl[1] = bus1.o_plus; mi[1] = bus1.o_minus; er[1] = bus1.o_err;
    endtask

    task automatic check_zero(input string tag);
        logic [1:0] ph [2];
        logic       pl [2], mi [2], er [2];
        sample(ph, pl, mi, er);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_plus_s%0d", tag, steps_m[k]), int'(pl[k]), 0);
            chk($sformatf("%s_minus_s%0d", tag, steps_m[k]), int'(mi[k]), 0);
            chk($sformatf("%s_err_s%0d", tag, steps_m[k]), int'(er[k]), 0);
            chk($sformatf("%s_phase_s%0d", tag, steps_m[k]), int'(ph[k]), 0);
        end
    endtask

    // Output seen in cycle m reflects contacts driven in cycles m-4 and m-3 and enable from m-1.
    task automatic check_model();
        int         m, d;
        bit         ill, en_v;
        logic [1:0] old_ab, new_ab, exp_ph;
        int         exp_p [2], exp_mn [2];
        int         exp_e;
        logic [1:0] ph [2];
        logic       pl [2], mi [2], er [2];
        sample(ph, pl, mi, er);
        m = ab_h.size();
        exp_p  = '{0, 0};
        exp_mn = '{0, 0};
        exp_e  = 0;
        exp_ph = 2'b00;
        if (m == 3) begin
            exp_ph = ab_h[0];
        end else if (m >= 4) begin
            old_ab = ab_h[m-4];
            new_ab = ab_h[m-3];
            en_v   = en_h[m-1];
            exp_ph = new_ab;
            d   = 0;
            ill = 1'b0;
            if (new_ab == old_ab)               d = 0;
            else if (cw_next(old_ab) == new_ab)  d = 1;
            else if (ccw_next(old_ab) == new_ab) d = -1;
            else                                 ill = 1'b1;
            exp_e = int'(ill);
            for (int k = 0; k < 2; k++) begin
                if (ill || !en_v) begin
                    acc_m[k] = 0;
                end else begin
                    acc_m[k] += d;
                    if (acc_m[k] == steps_m[k]) begin
                        exp_p[k] = 1; acc_m[k] = 0;
                    end else if (acc_m[k] == -steps_m[k]) begin
                        exp_mn[k] = 1; acc_m[k] = 0;
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("plus_s%0d_c%0d", steps_m[k], m), int'(pl[k]), exp_p[k]);
            chk($sformatf("minus_s%0d_c%0d", steps_m[k], m), int'(mi[k]), exp_mn[k]);
            chk($sformatf("err_s%0d_c%0d", steps_m[k], m), int'(er[k]), exp_e);
            chk($sformatf("phase_s%0d_c%0d", steps_m[k], m), int'(ph[k]), int'(exp_ph));
            cnt_p[k] += int'(pl[k]);
            cnt_m[k] += int'(mi[k]);
            cnt_e[k] += int'(er[k]);
        end
    endtask

    task automatic tick(input logic [1:0] ab, input logic en);
        @(negedge clk);
        check_model();
        drive(ab, en);
    endtask

    task automatic clear_counts();
        cnt_p = '{0, 0}; cnt_m = '{0, 0}; cnt_e = '{0, 0};
    endtask

    task automatic check_counts(input string tag, input int p4, input int m4, input int e,
                                input int p1, input int m1);
        chk({tag, "_plus_s4"},  cnt_p[0], p4);
        chk({tag, "_minus_s4"}, cnt_m[0], m4);
        chk({tag, "_err_s4"},   cnt_e[0], e);
        chk({tag, "_plus_s1"},  cnt_p[1], p1);
        chk({tag, "_minus_s1"}, cnt_m[1], m1);
        chk({tag, "_err_s1"},   cnt_e[1], e);
    endtask

    task automatic release_reset(input logic [1:0] ab, input logic en);
        @(negedge clk);
        rst_n = 1'b1;
        ab_h.delete();
        en_h.delete();
        acc_m = '{0, 0};
        drive(ab, en);
    endtask

    task automatic apply_row(input int idx, input row_t r);
        logic [11:0] s;
        logic [1:0]  last;
        s = r.seq;
        last = 2'b00;
        clear_counts();
        for (int i = 0; i < int'(r.len); i++) begin
            last = s[11-2*i -: 2];
            repeat (HOLD) tick(last, r.en);
        end
        repeat (4) tick(last, r.en);
        check_counts($sformatf("row%0d", idx), int'(r.p4), int'(r.m4), int'(r.e),
                     int'(r.p1), int'(r.m1));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : main
        row_t       rows [6];
        logic [1:0] cur, nxt;
        logic       en_r;
        int         r;

        rows[0] = '{seq:{2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00}, len:3'd5, en:1'b1,
                    p4:4'd1, m4:4'd0, e:4'd0, p1:4'd4, m1:4'd0};
        rows[1] = '{seq:{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01}, len:3'd6, en:1'b1,
                    p4:4'd0, m4:4'd1, e:4'd0, p1:4'd0, m1:4'd5};
        rows[2] = '{seq:{2'b01, 2'b11, 8'h00}, len:3'd2, en:1'b1,
                    p4:4'd0, m4:4'd0, e:4'd0, p1:4'd1, m1:4'd0};
        rows[3] = '{seq:{2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10}, len:3'd6, en:1'b0,
                    p4:4'd0, m4:4'd0, e:4'd0, p1:4'd0, m1:4'd0};
        rows[4] = '{seq:{2'b10, 2'b00, 2'b01, 2'b10, 4'h0}, len:3'd4, en:1'b1,
                    p4:4'd0, m4:4'd0, e:4'd1, p1:4'd2, m1:4'd0};
        rows[5] = '{seq:{2'b10, 2'b00, 2'b10, 6'h00}, len:3'd3, en:1'b1,
                    p4:4'd0, m4:4'd0, e:4'd0, p1:4'd1, m1:4'd1};

        bus4.i_a = 1'b1; bus4.i_b = 1'b1; bus4.i_en = 1'b1;
        bus1.i_a = 1'b1; bus1.i_b = 1'b1; bus1.i_en = 1'b1;
        clear_counts();
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_zero("por");
        end

        // Contacts resting at 11 through reset: phase 11 from the third edge, no pulses.
        release_reset(2'b11, 1'b1);
        clear_counts();
        repeat (100) tick(2'b11, 1'b1);
        check_counts("rest", 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) apply_row(i, rows[i]);

        // Partial detent, then asynchronous reset between clock edges.
        clear_counts();
        repeat (HOLD) tick(2'b10, 1'b1);
        repeat (HOLD) tick(2'b00, 1'b1);
        repeat (HOLD) tick(2'b01, 1'b1);
        check_counts("pre_rst", 0, 0, 0, 2, 0);
        #1 rst_n = 1'b0;
        #1 check_zero("async_rst");
        repeat (2) @(negedge clk);
        release_reset(2'b01, 1'b1);
        clear_counts();
        repeat (HOLD) tick(2'b01, 1'b1);
        repeat (HOLD) tick(2'b11, 1'b1);
        repeat (HOLD) tick(2'b10, 1'b1);
        repeat (HOLD) tick(2'b00, 1'b1);
        repeat (HOLD) tick(2'b01, 1'b1);
        repeat (4) tick(2'b01, 1'b1);
        check_counts("post_rst", 1, 0, 0, 4, 0);

        cur = 2'b01;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 2)       nxt = cw_next(cw_next(cur));
            else if (r < 10) nxt = cw_next(cur);
            else if (r < 17) nxt = ccw_next(cur);
            else             nxt = cur;
            en_r = ($urandom_range(0, 9) != 0);
            repeat ($urandom_range(1, 3)) tick(nxt, en_r);
            cur = nxt;
        end
        repeat (5) tick(cur, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
